pe_mc_router_buf: RTL and testbench
===================================

Name: pe_mc_router_buf

Overview:
- Per-PE multicast receive port: second-generation bus-to-PE router for the PE array.
- Captures a configurable ID match rule (exact, range, mask or broadcast) during configuration.
- Filters beats on the shared array bus by source ID and buffers matched beats in a small FIFO.
- Delivers beats to the PE over a valid/ready handshake, with selectable bus-stall or drop-and-count overflow policy.

Parameters:
- DATA_WIDTH, 16, bus/PE data width.
- ID_WIDTH, 8, source/config ID width.
- FIFO_DEPTH, 4, buffer entries; power of two, >=2.
- CNT_WIDTH, 16, drop counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- config_state  in  1  configuration phase active.
- ce  in  1  config capture enable.
- cfg_id_lo  in  ID_WIDTH  exact ID / range low / mask-mode reference ID.
- cfg_id_hi  in  ID_WIDTH  range high / mask-mode bit mask.
- cfg_mode  in  2  0 exact, 1 range, 2 mask, 3 broadcast.
- cfg_drop_en  in  1  1 = drop on overflow, 0 = stall bus.
- source_id  in  ID_WIDTH  ID tag of current bus beat.
- bus_data_in  in  DATA_WIDTH  bus payload.
- bus_data_valid  in  1  bus beat valid.
- bus_ready  out  1  this port can accept the current beat.
- pe_data_in  out  DATA_WIDTH  FIFO head data; 0 when pe_data_in_en=0.
- pe_data_in_en  out  1  FIFO head valid.
- pe_ready  in  1  PE consumes head.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_WIDTH  dropped-beat count, saturating.

Behaviour:
- Reset: async on rst_n low, all state cleared.
  - Config regs: lo=0, hi=0, mode=0, drop_en=0.
  - FIFO empty; pe_data_in_en=0, pe_data_in=0, fifo_level=0, drop_cnt=0, bus_ready=1.
  - Reset mid-transfer discards FIFO contents; no partial beat survives.
- Config capture: on a clock edge with config_state&&ce, register cfg_id_lo, cfg_id_hi, cfg_mode and cfg_drop_en.
  - The same edge flushes the FIFO (level=0) and clears drop_cnt.
  - Flush has priority over any same-cycle push or pop.
- match (combinational, from registered config only):
  - Forced 0 while config_state=1.
  - mode0: source_id==lo.
  - mode1: lo<=source_id<=hi, unsigned; lo>hi never matches.
  - mode2: (source_id & hi)==(lo & hi); hi=0 matches all.
  - mode3: always 1.
- full = (level==FIFO_DEPTH); empty = (level==0).
- bus_ready:
  - drop_en=0: bus_ready = !(match && full). Combinational; the bus holds the beat while low.
  - drop_en=1: bus_ready = 1.
- push = bus_data_valid && match && !full. Non-matching beats are ignored and have no effect.
- drop = bus_data_valid && match && full && drop_en.
  - drop_cnt += 1 per dropped beat, saturating at all-ones (no wrap).
  - In stall mode drop_cnt never increments.
- pop = pe_data_in_en && pe_ready.
- Latency: a beat pushed at edge N is visible on pe_data_in_en/pe_data_in after edge N (FIFO head registered, no combinational bus-to-PE path).
- Ordering: strict FIFO order; the head holds stable while pe_data_in_en=1 and pe_ready=0.
- Simultaneous push and pop:
  - Not full: both occur, level unchanged.
  - Full: push is blocked, because full is evaluated before the pop. A slot freed by a pop accepts data from the next cycle.
- Pointers wrap modulo FIFO_DEPTH. level is the authoritative count and never exceeds FIFO_DEPTH or underflows.
- pe_ready with FIFO empty: no effect.

Test Plan:
- Exact mode: lo=5. Beats ids 5,3,5 with data A1,B2,C3 on consecutive cycles, pe_ready=1 → PE sees A1 then C3, each one cycle after its bus cycle; B2 never appears; drop_cnt=0.
- Range and mask: mode1 lo=4, hi=7, ids 3,4,7,8 → only ids 4,7 accepted. mode2 lo=0x10, hi=0xF0, ids 0x1A,0x2A → only 0x1A accepted.
- Stall overflow: DEPTH=4, drop_en=0, pe_ready=0. Push 5 matching beats D0..D4 → level=4 and bus_ready=0 on the 5th. Raise pe_ready for one cycle → D0 out; D4 accepted the following cycle; final order D1..D4.
- Drop overflow: drop_en=1, pe_ready=0, 7 matching beats → level=4, drop_cnt=3, bus_ready stays 1. With CNT_WIDTH=2, 6 further drops → drop_cnt saturates at 3.
- Config flush: FIFO level=3 and drop_cnt=2, then config_state=ce=1 for one cycle with new lo → level=0, pe_data_in_en=0, drop_cnt=0. Bus beats during config_state are not accepted; a beat matching the new ID is accepted after config_state drops.
- Async reset: assert rst_n low mid-stream with level=2 → outputs reset immediately without a clock edge. After release, previously buffered data never appears and config is back to exact id 0.

Source files
------------

// File: rtl/pe_mc_router_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mc_router_buf
//  Description : Per-PE multicast receive port. Filters shared-bus beats by
//                source ID (exact / range / mask / broadcast rule captured in
//                configuration), buffers matches in a small FIFO and hands
//                them to the PE over valid/ready. Overflow either stalls the
//                bus or drops the beat and counts it (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_mc_router_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          config_state,
  input  logic                          ce,
  input  logic [ID_WIDTH-1:0]           cfg_id_lo,
  input  logic [ID_WIDTH-1:0]           cfg_id_hi,
  input  logic [1:0]                    cfg_mode,
  input  logic                          cfg_drop_en,
  input  logic [ID_WIDTH-1:0]           source_id,
  input  logic [DATA_WIDTH-1:0]         bus_data_in,
  input  logic                          bus_data_valid,
  output logic                          bus_ready,
  output logic [DATA_WIDTH-1:0]         pe_data_in,
  output logic                          pe_data_in_en,
  input  logic                          pe_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [1:0]           c_MODE_EXACT = 2'd0;
  localparam logic [1:0]           c_MODE_RANGE = 2'd1;
  localparam logic [1:0]           c_MODE_MASK  = 2'd2;
  localparam logic [c_LVL_W-1:0]   c_FULL_LEVEL = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_LVL_W-1:0]   c_LVL_ONE    = {{(c_LVL_W-1){1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE    = {{(c_PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [ID_WIDTH-1:0]   r_cfg_lo;
  logic [ID_WIDTH-1:0]   r_cfg_hi;
  logic [1:0]            r_cfg_mode;
  logic                  r_cfg_drop_en;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0]    r_level;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

  logic w_match;
  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Source-ID filter, driven only by the registered rule; muted during config
  always_comb begin
    w_match = 1'b0;
    if (!config_state) begin
      case (r_cfg_mode)
        c_MODE_EXACT: w_match = (source_id == r_cfg_lo);
        c_MODE_RANGE: w_match = (source_id >= r_cfg_lo) && (source_id <= r_cfg_hi);
        c_MODE_MASK:  w_match = ((source_id & r_cfg_hi) == (r_cfg_lo & r_cfg_hi));
        default:      w_match = 1'b1;
      endcase
    end
  end

  // full is judged on the current level, so a same-cycle pop never frees a slot early
  assign w_full    = (r_level == c_FULL_LEVEL);
  assign w_empty   = (r_level == '0);
  assign w_flush   = config_state && ce;
  assign w_push    = bus_data_valid && w_match && !w_full;
  assign w_pop     = !w_empty && pe_ready;
  assign w_drop    = bus_data_valid && w_match && w_full && r_cfg_drop_en;

  assign bus_ready     = r_cfg_drop_en || !(w_match && w_full);
  assign pe_data_in_en = !w_empty;
  assign pe_data_in    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level    = r_level;
  assign drop_cnt      = r_drop_cnt;

  // Config capture, FIFO bookkeeping and drop counting; flush beats push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_lo      <= '0;
      r_cfg_hi      <= '0;
      r_cfg_mode    <= c_MODE_EXACT;
      r_cfg_drop_en <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_drop_cnt    <= '0;
    end else if (w_flush) begin
      r_cfg_lo      <= cfg_id_lo;
      r_cfg_hi      <= cfg_id_hi;
      r_cfg_mode    <= cfg_mode;
      r_cfg_drop_en <= cfg_drop_en;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LVL_ONE;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - c_LVL_ONE;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
      end
    end
  end

  // Storage array; cleared on reset so nothing buffered before reset can resurface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= bus_data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_mc_router_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_mc_router_buf
//  Description : Directed, table-driven bench for pe_mc_router_buf. A second
//                instance with a 2-bit drop counter shares all inputs so that
//                counter saturation is observed alongside the wide counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mc_router_buf;

  logic        clk;
  logic        rst_n;
  logic        config_state;
  logic        ce;
  logic [7:0]  cfg_id_lo;
  logic [7:0]  cfg_id_hi;
  logic [1:0]  cfg_mode;
  logic        cfg_drop_en;
  logic [7:0]  source_id;
  logic [15:0] bus_data_in;
  logic        bus_data_valid;
  logic        pe_ready;

  logic        bus_ready;
  logic [15:0] pe_data_in;
  logic        pe_data_in_en;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;

  logic        bus_ready2;
  logic [15:0] pe_data_in2;
  logic        pe_data_in_en2;
  logic [2:0]  fifo_level2;
  logic [1:0]  drop_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  pe_mc_router_buf dut (
    .clk(clk), .rst_n(rst_n), .config_state(config_state), .ce(ce),
    .cfg_id_lo(cfg_id_lo), .cfg_id_hi(cfg_id_hi), .cfg_mode(cfg_mode),
    .cfg_drop_en(cfg_drop_en), .source_id(source_id), .bus_data_in(bus_data_in),
    .bus_data_valid(bus_data_valid), .bus_ready(bus_ready), .pe_data_in(pe_data_in),
    .pe_data_in_en(pe_data_in_en), .pe_ready(pe_ready), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
  );

  pe_mc_router_buf #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .config_state(config_state), .ce(ce),
    .cfg_id_lo(cfg_id_lo), .cfg_id_hi(cfg_id_hi), .cfg_mode(cfg_mode),
    .cfg_drop_en(cfg_drop_en), .source_id(source_id), .bus_data_in(bus_data_in),
    .bus_data_valid(bus_data_valid), .bus_ready(bus_ready2), .pe_data_in(pe_data_in2),
    .pe_data_in_en(pe_data_in_en2), .pe_ready(pe_ready), .fifo_level(fifo_level2),
    .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        ce;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  mode;
    logic        de;
    logic [7:0]  src;
    logic [15:0] data;
    logic        valid;
    logic        pr;
    logic        exp_br;
    logic        exp_en;
    logic [15:0] exp_data;
    logic [2:0]  exp_level;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic cs, input logic c, input logic [7:0] lo,
                              input logic [7:0] hi, input logic [1:0] mode, input logic de,
                              input logic [7:0] src, input logic [15:0] data,
                              input logic valid, input logic pr, input logic br,
                              input logic en, input logic [15:0] dat,
                              input logic [2:0] lvl, input logic [15:0] drp);
    vec_t v;
    v.cs = cs; v.ce = c; v.lo = lo; v.hi = hi; v.mode = mode; v.de = de;
    v.src = src; v.data = data; v.valid = valid; v.pr = pr;
    v.exp_br = br; v.exp_en = en; v.exp_data = dat; v.exp_level = lvl; v.exp_drop = drp;
    vq.push_back(v);
  endfunction

  // Configuration cycle: bus idle, FIFO flushed and counter cleared afterwards
  function automatic void cfg(input logic [7:0] lo, input logic [7:0] hi,
                              input logic [1:0] mode, input logic de);
    add(1'b1, 1'b1, lo, hi, mode, de, 8'h00, 16'h0000, 1'b0, 1'b0,
        1'b1, 1'b0, 16'h0000, 3'd0, 16'd0);
  endfunction

  function automatic void beat(input logic [7:0] src, input logic [15:0] data,
                               input logic valid, input logic pr, input logic br,
                               input logic en, input logic [15:0] dat,
                               input logic [2:0] lvl, input logic [15:0] drp);
    add(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, src, data, valid, pr, br, en, dat, lvl, drp);
  endfunction

  // Inputs applied just after a rising edge; bus_ready checked before the next
  // edge, registered outputs checked just after it
  task automatic apply(input vec_t v, input string tag);
    logic [15:0] exp2;
    config_state   = v.cs;
    ce             = v.ce;
    cfg_id_lo      = v.lo;
    cfg_id_hi      = v.hi;
    cfg_mode       = v.mode;
    cfg_drop_en    = v.de;
    source_id      = v.src;
    bus_data_in    = v.data;
    bus_data_valid = v.valid;
    pe_ready       = v.pr;
    #1;
    chk({tag, ".bus_ready"}, {31'd0, bus_ready}, {31'd0, v.exp_br});
    @(posedge clk);
    #1;
    exp2 = (v.exp_drop > 16'd3) ? 16'd3 : v.exp_drop;
    chk({tag, ".pe_data_in_en"}, {31'd0, pe_data_in_en}, {31'd0, v.exp_en});
    chk({tag, ".pe_data_in"}, {16'd0, pe_data_in}, {16'd0, v.exp_data});
    chk({tag, ".fifo_level"}, {29'd0, fifo_level}, {29'd0, v.exp_level});
    chk({tag, ".drop_cnt"}, {16'd0, drop_cnt}, {16'd0, v.exp_drop});
    chk({tag, ".drop_cnt_w2"}, {30'd0, drop_cnt2}, {16'd0, exp2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b1; config_state = 1'b0; ce = 1'b0; cfg_id_lo = '0; cfg_id_hi = '0;
    cfg_mode = '0; cfg_drop_en = 1'b0; source_id = '0; bus_data_in = '0;
    bus_data_valid = 1'b0; pe_ready = 1'b0;

    // Exact mode: 5,3,5 -> A1 then C3
    cfg(8'd5, 8'd0, 2'd0, 1'b0);
    beat(8'd5, 16'h00A1, 1, 1, 1, 1, 16'h00A1, 3'd1, 16'd0);
    beat(8'd3, 16'h00B2, 1, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    beat(8'd5, 16'h00C3, 1, 1, 1, 1, 16'h00C3, 3'd1, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    // Range 4..7
    cfg(8'd4, 8'd7, 2'd1, 1'b0);
    beat(8'd3, 16'h0003, 1, 0, 1, 0, 16'h0000, 3'd0, 16'd0);
    beat(8'd4, 16'h0004, 1, 0, 1, 1, 16'h0004, 3'd1, 16'd0);
    beat(8'd7, 16'h0007, 1, 0, 1, 1, 16'h0004, 3'd2, 16'd0);
    beat(8'd8, 16'h0008, 1, 0, 1, 1, 16'h0004, 3'd2, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 1, 16'h0007, 3'd1, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    // Mask: ref 0x10, mask 0xF0
    cfg(8'h10, 8'hF0, 2'd2, 1'b0);
    beat(8'h1A, 16'h011A, 1, 0, 1, 1, 16'h011A, 3'd1, 16'd0);
    beat(8'h2A, 16'h012A, 1, 0, 1, 1, 16'h011A, 3'd1, 16'd0);
    beat(8'h00, 16'h0000, 0, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    // Broadcast
    cfg(8'd0, 8'd0, 2'd3, 1'b0);
    beat(8'hFF, 16'hBEEF, 1, 1, 1, 1, 16'hBEEF, 3'd1, 16'd0);
    beat(8'h00, 16'h0000, 0, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    // Stall overflow
    cfg(8'd9, 8'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      beat(8'd9, 16'h00D0 + 16'(i), 1, 0, 1, 1, 16'h00D0, 3'(i + 1), 16'd0);
    beat(8'd9, 16'h00D4, 1, 0, 0, 1, 16'h00D0, 3'd4, 16'd0);
    beat(8'd9, 16'h00D4, 1, 1, 0, 1, 16'h00D1, 3'd3, 16'd0);
    beat(8'd9, 16'h00D4, 1, 0, 1, 1, 16'h00D1, 3'd4, 16'd0);
    beat(8'd9, 16'h0000, 0, 1, 0, 1, 16'h00D2, 3'd3, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 1, 16'h00D3, 3'd2, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 1, 16'h00D4, 3'd1, 16'd0);
    beat(8'd0, 16'h0000, 0, 1, 1, 0, 16'h0000, 3'd0, 16'd0);
    // Drop overflow, 13 beats into a 4-deep FIFO
    cfg(8'd9, 8'd0, 2'd0, 1'b1);
    for (int i = 0; i < 13; i++)
      beat(8'd9, 16'h00E0 + 16'(i), 1, 0, 1, 1, 16'h00E0,
           (i < 4) ? 3'(i + 1) : 3'd4, (i < 4) ? 16'd0 : 16'(i - 3));
    // Flush: build level=3, drop_cnt=2
    cfg(8'd9, 8'd0, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++)
      beat(8'd9, 16'h0030 + 16'(i), 1, 0, 1, 1, 16'h0030,
           (i < 4) ? 3'(i + 1) : 3'd4, (i < 4) ? 16'd0 : 16'(i - 3));
    beat(8'd0, 16'h0000, 0, 1, 1, 1, 16'h0031, 3'd3, 16'd2);
    add(1, 1, 8'h22, 8'h00, 2'd0, 1'b1, 8'h22, 16'h0099, 1, 0, 1, 0, 16'h0000, 3'd0, 16'd0);
    add(1, 0, 8'h00, 8'h00, 2'd0, 1'b0, 8'h22, 16'h0098, 1, 0, 1, 0, 16'h0000, 3'd0, 16'd0);
    beat(8'h22, 16'h0097, 1, 0, 1, 1, 16'h0097, 3'd1, 16'd0);
    beat(8'h09, 16'h0096, 1, 0, 1, 1, 16'h0097, 3'd1, 16'd0);
    beat(8'h22, 16'h0095, 1, 0, 1, 1, 16'h0097, 3'd2, 16'd0);

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset.pe_data_in_en", {31'd0, pe_data_in_en}, 32'd0);
    chk("reset.pe_data_in", {16'd0, pe_data_in}, 32'd0);
    chk("reset.fifo_level", {29'd0, fifo_level}, 32'd0);
    chk("reset.drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("reset.bus_ready", {31'd0, bus_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k], $sformatf("vec%0d", k));
    end

    // Asynchronous reset mid-stream with two beats buffered
    bus_data_valid = 1'b0;
    pe_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset.pe_data_in_en", {31'd0, pe_data_in_en}, 32'd0);
    chk("areset.pe_data_in", {16'd0, pe_data_in}, 32'd0);
    chk("areset.fifo_level", {29'd0, fifo_level}, 32'd0);
    chk("areset.bus_ready", {31'd0, bus_ready}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset.pe_data_in_en", {31'd0, pe_data_in_en}, 32'd0);
    chk("post_reset.fifo_level", {29'd0, fifo_level}, 32'd0);
    // Config back to exact ID 0: 0x22 rejected, 0x00 accepted
    v = '{cs: 1'b0, ce: 1'b0, lo: 8'h00, hi: 8'h00, mode: 2'd0, de: 1'b0, src: 8'h22,
          data: 16'h0066, valid: 1'b1, pr: 1'b0, exp_br: 1'b1, exp_en: 1'b0,
          exp_data: 16'h0000, exp_level: 3'd0, exp_drop: 16'd0};
    apply(v, "post_reset_id22");
    v.src = 8'h00; v.data = 16'h0055; v.exp_en = 1'b1; v.exp_data = 16'h0055; v.exp_level = 3'd1;
    apply(v, "post_reset_id0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
